seg7_mux_driver: RTL

SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

---
 rtl/seg7_mux_driver.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seg7_mux_driver.sv
// Multiplexed 7-segment driver: GAP/DRIVE scan over NUM_DIGITS hex digits with frame-synchronous updates.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 25000,
    parameter int GAP_CYCLES     = 2,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic                    i_Load,
    input  logic                    i_Blank,
    output logic [6:0]              o_Segments,
    output logic [NUM_DIGITS-1:0]   o_Digit_En,
    output logic                    o_Frame_Done
);

    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX = (REFRESH_CYCLES > GAP_CYCLES) ? REFRESH_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {ST_GAP, ST_DRIVE} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [IW-1:0]           idx_q;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [4*NUM_DIGITS-1:0] active_q;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   en_q;
    logic                    done_q;

    logic [3:0]              nib;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   en_d;

    function automatic logic [6:0] encode(input logic [3:0] n);
        case (n)
            4'h0: encode = 7'h7E;
            4'h1: encode = 7'h30;
            4'h2: encode = 7'h6D;
            4'h3: encode = 7'h79;
            4'h4: encode = 7'h33;
            4'h5: encode = 7'h5B;
            4'h6: encode = 7'h5F;
            4'h7: encode = 7'h70;
            4'h8: encode = 7'h7F;
            4'h9: encode = 7'h7B;
            4'hA: encode = 7'h77;
            4'hB: encode = 7'h1F;
            4'hC: encode = 7'h4E;
            4'hD: encode = 7'h3D;
            4'hE: encode = 7'h4F;
            default: encode = 7'h47;
        endcase
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [IW-1:0] msd;

    // Highest nonzero nibble; stays 0 when all digits are zero so digit 0 is always shown.
    always_comb begin
        msd = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (active_q[4*i +: 4] != 4'h0) msd = IW'(i);
        end
    end
`endif

    always_comb begin
        nib  = '0;
        en_d = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib     = active_q[4*i +: 4];
                en_d[i] = 1'b1;
            end
        end
        if (state_q != ST_DRIVE) en_d = '0;

        seg_d = encode(nib);
        if (state_q != ST_DRIVE || i_Blank) seg_d = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx_q > msd) seg_d = '0;
`endif
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q  <= ST_GAP;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            seg_q    <= '0;
            en_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            en_q   <= en_d;
            done_q <= 1'b0;
            if (i_Load) shadow_q <= i_Value;

            case (state_q)
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_DRIVE;
                        // Frame start: the only point where displayed data may change.
                        if (idx_q == '0) active_q <= shadow_q;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                        if (idx_q == IDX_LAST) begin
                            idx_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_GAP;
            endcase
        end
    end

    assign o_Segments   = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign o_Digit_En   = (ACTIVE_LOW != 0) ? ~en_q  : en_q;
    assign o_Frame_Done = done_q;

endmodule
